// File: rtl/alu_pkg.sv
// Shared types and widths for the sequential ALU command path.
package alu_pkg;

    localparam int DATA_W = 4;
    localparam int FUNC_W = 3;
    localparam int RES_W  = 8;

    typedef enum logic [FUNC_W-1:0] {
        FUNC_ADD  = 3'd0,
        FUNC_MUL  = 3'd1,
        FUNC_SHL  = 3'd2,
        FUNC_HOLD = 3'd3
    } alu_func_e;

    typedef struct packed {
        logic              clr;
        logic [FUNC_W-1:0] func;
        logic [DATA_W-1:0] data;
    } alu_cmd_t;

    typedef enum logic [1:0] {
        SEQ_IDLE    = 2'd0,
        SEQ_ISSUE   = 2'd1,
        SEQ_CAPTURE = 2'd2,
        SEQ_RESULT  = 2'd3
    } seq_state_e;

    // A clear entry must not also apply an operation, so it is issued as HOLD.
    function automatic logic [FUNC_W-1:0] issue_func(input alu_cmd_t cmd);
        return cmd.clr ? FUNC_HOLD : cmd.func;
    endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous FIFO of ALU commands; pointers wrap naturally since DEPTH is a power of two.
module alu_cmd_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  alu_cmd_t                   wr_data,
    input  logic                       pop,
    output alu_cmd_t                   rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    alu_cmd_t           mem_r [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [CNT_W-1:0]   count_r;
    logic               wr_en_s;
    logic               rd_en_s;

    assign full    = (count_r == CNT_W'(DEPTH));
    assign empty   = (count_r == {CNT_W{1'b0}});
    assign count   = count_r;
    assign rd_data = mem_r[rd_ptr_r];
    assign wr_en_s = push && !full;
    assign rd_en_s = pop && !empty;

    // Storage, pointers and occupancy; simultaneous push and pop leave count unchanged.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else begin
            if (wr_en_s) begin
                mem_r[wr_ptr_r] <= wr_data;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end
            if (rd_en_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({wr_en_s, rd_en_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Queues ALU commands, drives the sequential ALU one op at a time and
// returns each captured ALU register value over a valid/ready port.
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              Clock,
    input  logic              Reset_b,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [DATA_W-1:0] cmd_data,
    input  logic [FUNC_W-1:0] cmd_func,
    input  logic              cmd_clr,
    output logic [DATA_W-1:0] alu_data,
    output logic [FUNC_W-1:0] alu_func,
    output logic              alu_clr_b,
    input  logic [RES_W-1:0]  alu_result,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [RES_W-1:0]  res_data,
    output logic              busy
);

    localparam int CNT_W = $clog2(DEPTH+1);

    localparam logic [1:0] ST_IDLE    = SEQ_IDLE;
    localparam logic [1:0] ST_ISSUE   = SEQ_ISSUE;
    localparam logic [1:0] ST_CAPTURE = SEQ_CAPTURE;
    localparam logic [1:0] ST_RESULT  = SEQ_RESULT;

    alu_cmd_t           cmd_in_s;
    alu_cmd_t           head_s;
    logic               push_s;
    logic               pop_s;
    logic               full_s;
    logic               empty_s;
    logic [CNT_W-1:0]   count_s;
    logic [1:0]         state_r;
    logic [1:0]         next_state_s;
    logic [DATA_W-1:0]  alu_data_r;
    logic [FUNC_W-1:0]  alu_func_r;
    logic               alu_clr_b_r;
    logic               res_valid_r;
    logic [RES_W-1:0]   res_data_r;

    assign cmd_in_s  = '{clr: cmd_clr, func: cmd_func, data: cmd_data};
    assign cmd_ready = (count_s != CNT_W'(DEPTH));
    assign push_s    = cmd_valid && !full_s;
    assign busy      = !empty_s || (state_r != ST_IDLE);
    assign alu_data  = alu_data_r;
    assign alu_func  = alu_func_r;
    assign alu_clr_b = alu_clr_b_r;
    assign res_valid = res_valid_r;
    assign res_data  = res_data_r;

    alu_cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (Clock),
        .rst_n   (Reset_b),
        .push    (push_s),
        .wr_data (cmd_in_s),
        .pop     (pop_s),
        .rd_data (head_s),
        .full    (full_s),
        .empty   (empty_s),
        .count   (count_s)
    );

    // Next-state and pop decision; RESULT chains straight into ISSUE when work is queued.
    always_comb begin
        pop_s        = 1'b0;
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (!empty_s) begin
                    pop_s        = 1'b1;
                    next_state_s = ST_ISSUE;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_ISSUE:   next_state_s = ST_CAPTURE;
            ST_CAPTURE: next_state_s = ST_RESULT;
            ST_RESULT: begin
                if (res_valid_r && res_ready) begin
                    if (!empty_s) begin
                        pop_s        = 1'b1;
                        next_state_s = ST_ISSUE;
                    end else begin
                        next_state_s = ST_IDLE;
                    end
                end else begin
                    next_state_s = ST_RESULT;
                end
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // FSM state, ALU drive registers and result register.
    always_ff @(posedge Clock) begin
        if (!Reset_b) begin
            state_r     <= ST_IDLE;
            alu_data_r  <= {DATA_W{1'b0}};
            alu_func_r  <= FUNC_HOLD;
            alu_clr_b_r <= 1'b1;
            res_valid_r <= 1'b0;
            res_data_r  <= {RES_W{1'b0}};
        end else begin
            state_r <= next_state_s;
            // ALU stimulus is non-HOLD only for the single ISSUE cycle after a pop.
            if (pop_s) begin
                alu_data_r  <= head_s.clr ? {DATA_W{1'b0}} : head_s.data;
                alu_func_r  <= issue_func(head_s);
                alu_clr_b_r <= ~head_s.clr;
            end else begin
                alu_func_r  <= FUNC_HOLD;
                alu_clr_b_r <= 1'b1;
            end
            if (state_r == ST_CAPTURE) begin
                res_data_r  <= alu_result;
                res_valid_r <= 1'b1;
            end else if (res_valid_r && res_ready) begin
                res_valid_r <= 1'b0;
            end else begin
                res_valid_r <= res_valid_r;
            end
        end
    end

endmodule
